seq_comparator_nbit: RTL and testbench

- Parametrised, clocked magnitude comparator; next generation of the team's 1-bit/2-bit gate-level comparators.
- Accepts operand pairs of WIDTH bits over a valid/ready handshake and compares them serially, one bit per cycle, MSB first (bit-serial mode).
- Alternatively compares in a single cycle (parallel mode).
- Registers less/equal/greater flags plus running min/max tracking; sits in the lab datapath between stimulus generators and the LED/7-seg display.

---
 rtl/seq_comparator_nbit.sv | 153 +++++++++++++++
 tb/tb_seq_comparator_nbit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_comparator_nbit.sv
// Clocked WIDTH-bit magnitude comparator, either bit-serial (MSB first) or single-cycle, with running min/max of A.
// Optional 74HC85-style cascade inputs are enabled with `define COMP_CASCADE_EN.
module seq_comparator_nbit #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             l,
  output logic             e,
  output logic             g,
  output logic             out_valid,
  output logic             busy,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] max_seen,
  output logic [WIDTH-1:0] min_seen
`ifdef COMP_CASCADE_EN
  ,
  input  logic             l_in,
  input  logic             e_in,
  input  logic             g_in
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    TOP     = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  localparam logic [WIDTH-1:0] MAX_VAL = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [IW-1:0]    idx_q;
  logic             decided, lt_q, gt_q;
  logic             accept, msb_inv, bit_a, bit_b;
  logic             par_lt, par_gt, loc_lt, loc_gt;
  logic             res_l, res_e, res_g;
  logic             a_gt_max, a_lt_min;
  logic             cas_l, cas_e, cas_g, cas_onehot;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mode ? DONE : SHIFT;
      SHIFT:   if (idx_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  assign accept = in_valid && in_ready;

  // The MSB of a two's-complement operand carries negative weight, so its sense flips.
  assign bit_a   = a_q[idx_q];
  assign bit_b   = b_q[idx_q];
  assign msb_inv = SIGNED && (idx_q == TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; mode_q <= 1'b0; idx_q <= '0;
      decided <= 1'b0; lt_q <= 1'b0; gt_q <= 1'b0;
    end else if (accept) begin
      a_q <= a; b_q <= b; mode_q <= mode; idx_q <= TOP;
      decided <= 1'b0; lt_q <= 1'b0; gt_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      idx_q <= idx_q - 1'b1;
      if (!decided && (bit_a != bit_b)) begin
        decided <= 1'b1;
        gt_q    <= bit_a ^ msb_inv;
        lt_q    <= bit_b ^ msb_inv;
      end
    end
  end

`ifdef COMP_CASCADE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cas_l <= 1'b0; cas_e <= 1'b1; cas_g <= 1'b0;
    end else if (accept) begin
      cas_l <= l_in; cas_e <= e_in; cas_g <= g_in;
    end
  end
`else
  assign cas_l = 1'b0;
  assign cas_e = 1'b1;
  assign cas_g = 1'b0;
`endif

  assign cas_onehot = ({1'b0, cas_l} + {1'b0, cas_e} + {1'b0, cas_g}) == 2'd1;

  assign par_lt   = SIGNED ? ($signed(a_q) < $signed(b_q))      : (a_q < b_q);
  assign par_gt   = SIGNED ? ($signed(a_q) > $signed(b_q))      : (a_q > b_q);
  assign a_gt_max = SIGNED ? ($signed(a_q) > $signed(max_seen)) : (a_q > max_seen);
  assign a_lt_min = SIGNED ? ($signed(a_q) < $signed(min_seen)) : (a_q < min_seen);

  // Local inequality wins; a local tie defers to the cascade inputs.
  always_comb begin
    loc_lt = mode_q ? par_lt : lt_q;
    loc_gt = mode_q ? par_gt : gt_q;
    res_l  = loc_lt;
    res_e  = 1'b0;
    res_g  = loc_gt;
    if (!loc_lt && !loc_gt) begin
      if (cas_onehot) {res_l, res_e, res_g} = {cas_l, cas_e, cas_g};
      else            res_e = cas_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l <= 1'b0; e <= 1'b0; g <= 1'b0; out_valid <= 1'b0;
    end else begin
      out_valid <= (state_q == DONE);
      if (state_q == DONE) begin
        l <= res_l; e <= res_e; g <= res_g;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_seen <= MIN_VAL;
      min_seen <= MAX_VAL;
    end else if (clr_stats) begin
      max_seen <= MIN_VAL;
      min_seen <= MAX_VAL;
    end else if (state_q == DONE) begin
      if (a_gt_max) max_seen <= a_q;
      if (a_lt_min) min_seen <= a_q;
    end
  end

endmodule

// File: tb/tb_seq_comparator_nbit.sv
// Directed bench: an unsigned and a signed comparator share one stimulus stream.
module tb_seq_comparator_nbit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       mode = 1'b0, in_valid = 1'b0, clr_stats = 1'b0;
  logic       in_ready_u, l_u, e_u, g_u, ov_u, busy_u;
  logic       in_ready_s, l_s, e_s, g_s, ov_s, busy_s;
  logic [7:0] max_u, min_u, max_s, min_s;
`ifdef COMP_CASCADE_EN
  logic       l_in = 1'b0, e_in = 1'b1, g_in = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_comparator_nbit #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_u), .l(l_u), .e(e_u), .g(g_u), .out_valid(ov_u), .busy(busy_u),
    .clr_stats(clr_stats), .max_seen(max_u), .min_seen(min_u)
`ifdef COMP_CASCADE_EN
    , .l_in(l_in), .e_in(e_in), .g_in(g_in)
`endif
  );

  seq_comparator_nbit #(.WIDTH(8), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_s), .l(l_s), .e(e_s), .g(g_s), .out_valid(ov_s), .busy(busy_s),
    .clr_stats(clr_stats), .max_seen(max_s), .min_seen(min_s)
`ifdef COMP_CASCADE_EN
    , .l_in(l_in), .e_in(e_in), .g_in(g_in)
`endif
  );

  // One compare; returns cycles from accept edge to out_valid (0 on timeout) and both flag sets.
  task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb_v, input logic tm,
                         output int lat, output logic [2:0] fu, output logic [2:0] fs,
                         output logic rdy);
    lat = 0; fu = '0; fs = '0; rdy = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = 8'h5A;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ov_u) begin
        lat = ov_s ? i : -i;
        fu  = {l_u, e_u, g_u};
        fs  = {l_s, e_s, g_s};
        rdy = in_ready_u && in_ready_s;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_u, in_ready_u, l_u, e_u, g_u, ov_u} !== 6'b010000) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 010000", {busy_u, in_ready_u, l_u, e_u, g_u, ov_u});
    end
    n_cmp++;
    if ({max_u, min_u, max_s, min_s} !== 32'h00FF807F) begin
      n_bad++; $display("FAIL reset_stats: got %h want 00ff807f", {max_u, min_u, max_s, min_s});
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic [2:0] fu, fs; logic rdy;
    run_cmp(8'hA5, 8'hA4, 1'b0, lat, fu, fs, rdy);
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL serial_latency: got %0d want 9", lat); end
    n_cmp++;
    if ({fu, fs, rdy} !== 7'b001_001_1) begin
      n_bad++; $display("FAIL serial_a5_a4: got %b want 0010011", {fu, fs, rdy});
    end
    run_cmp(8'hA5, 8'hA4, 1'b1, lat, fu, fs, rdy);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL parallel_latency: got %0d want 1", lat); end
    n_cmp++;
    if ({fu, fs, rdy} !== 7'b001_001_1) begin
      n_bad++; $display("FAIL parallel_a5_a4: got %b want 0010011", {fu, fs, rdy});
    end
  endtask

  task automatic test_signed();
    int lat; logic [2:0] fu, fs; logic rdy;
    logic [7:0] va [4] = '{8'hFF, 8'hFF, 8'h80, 8'h00};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h7F, 8'hFF};
    logic       vm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0] ve [4] = '{6'b001_100, 6'b001_100, 6'b001_100, 6'b100_001};
    for (int k = 0; k < 4; k++) begin
      run_cmp(va[k], vb[k], vm[k], lat, fu, fs, rdy);
      n_cmp++;
      if ({fu, fs} !== ve[k] || lat !== (vm[k] ? 1 : 9)) begin
        n_bad++; $display("FAIL signed_vec%0d: got %b lat %0d want %b lat %0d", k, {fu, fs}, lat, ve[k], vm[k] ? 1 : 9);
      end
    end
  endtask

  task automatic test_equal_hold();
    int lat; logic [2:0] fu, fs; logic rdy;
    for (int m = 0; m < 2; m++) begin
      run_cmp(8'h3C, 8'h3C, m[0], lat, fu, fs, rdy);
      n_cmp++;
      if ({fu, fs} !== 6'b010_010 || lat !== (m == 1 ? 1 : 9)) begin
        n_bad++; $display("FAIL equal_mode%0d: got %b lat %0d want 010010", m, {fu, fs}, lat);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({l_u, e_u, g_u, ov_u, l_s, e_s, g_s, ov_s} !== 8'b0100_0100) begin
      n_bad++; $display("FAIL equal_hold: got %b want 01000100", {l_u, e_u, g_u, ov_u, l_s, e_s, g_s, ov_s});
    end
  endtask

  task automatic test_back_to_back();
    int cnt, p1, p2, p3; logic rdy_seen;
    // Serial: in_valid held high; second accept only after the first result.
    @(negedge clk); a = 8'h10; b = 8'h20; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    cnt = 0; p1 = 0; p2 = 0; rdy_seen = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
      if (i < 9 && in_ready_u) rdy_seen = 1'b1;
      if (ov_u) begin cnt++; if (cnt == 1) p1 = i; else p2 = i; end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cnt !== 2 || p1 !== 9 || p2 !== 19 || rdy_seen !== 1'b0) begin
      n_bad++; $display("FAIL b2b_serial: got n=%0d at %0d,%0d rdy=%b want n=2 at 9,19 rdy=0", cnt, p1, p2, rdy_seen);
    end
    // Parallel: one result every two cycles.
    @(negedge clk); mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    cnt = 0; p1 = 0; p2 = 0; p3 = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (ov_u) begin
        cnt++;
        if (cnt == 1) p1 = i; else if (cnt == 2) p2 = i; else p3 = i;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cnt !== 3 || p1 !== 1 || p2 !== 3 || p3 !== 5 || {l_u, e_u, g_u} !== 3'b100) begin
      n_bad++; $display("FAIL b2b_parallel: got n=%0d at %0d,%0d,%0d flags %b want n=3 at 1,3,5 flags 100",
                        cnt, p1, p2, p3, {l_u, e_u, g_u});
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ov_u !== 1'b0 || in_ready_u !== 1'b1) begin
      n_bad++; $display("FAIL b2b_drain: got ov=%b rdy=%b want ov=0 rdy=1", ov_u, in_ready_u);
    end
  endtask

  task automatic test_stats();
    int lat; logic [2:0] fu, fs; logic rdy;
    logic [7:0] seq [3] = '{8'd5, 8'd200, 8'd17};
    do_reset();
    for (int k = 0; k < 3; k++) run_cmp(seq[k], 8'h00, 1'b1, lat, fu, fs, rdy);
    n_cmp++;
    if ({max_u, min_u, max_s, min_s} !== 32'hC8_05_11_C8) begin
      n_bad++; $display("FAIL stats_track: got %h want c80511c8", {max_u, min_u, max_s, min_s});
    end
    // clr_stats coincides with the DONE that would record A=99.
    @(negedge clk); a = 8'd99; b = 8'h00; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    n_cmp++;
    if ({ov_u, max_u, min_u, max_s, min_s} !== {1'b1, 32'h00FF807F}) begin
      n_bad++; $display("FAIL stats_clear: got %b %h want 1 00ff807f", ov_u, {max_u, min_u, max_s, min_s});
    end
    run_cmp(8'h2A, 8'h00, 1'b0, lat, fu, fs, rdy);
    n_cmp++;
    if ({max_u, min_u, max_s, min_s} !== 32'h2A2A2A2A) begin
      n_bad++; $display("FAIL stats_after_clear: got %h want 2a2a2a2a", {max_u, min_u, max_s, min_s});
    end
  endtask

  task automatic test_abort();
    int cnt;
    @(negedge clk); a = 8'h80; b = 8'h7F; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_u, in_ready_u, l_u, e_u, g_u, ov_u, busy_s, in_ready_s} !== 8'b010000_01) begin
      n_bad++; $display("FAIL abort_state: got %b want 01000001", {busy_u, in_ready_u, l_u, e_u, g_u, ov_u, busy_s, in_ready_s});
    end
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov_u || ov_s || busy_u) cnt++;
    end
    n_cmp++;
    if (cnt !== 0 || max_u !== 8'h00) begin
      n_bad++; $display("FAIL abort_no_result: got %0d events max %h want 0 events max 00", cnt, max_u);
    end
  endtask

`ifdef COMP_CASCADE_EN
  task automatic test_cascade();
    int lat; logic [2:0] fu, fs; logic rdy;
    l_in = 1'b0; e_in = 1'b0; g_in = 1'b1;
    run_cmp(8'h10, 8'h10, 1'b0, lat, fu, fs, rdy);
    n_cmp++;
    if ({fu, fs} !== 6'b001_001) begin n_bad++; $display("FAIL cascade_tie: got %b want 001001", {fu, fs}); end
    l_in = 1'b1; e_in = 1'b0; g_in = 1'b0;
    run_cmp(8'h11, 8'h10, 1'b1, lat, fu, fs, rdy);
    n_cmp++;
    if ({fu, fs} !== 6'b001_001) begin n_bad++; $display("FAIL cascade_local: got %b want 001001", {fu, fs}); end
    l_in = 1'b1; e_in = 1'b0; g_in = 1'b1;
    run_cmp(8'h22, 8'h22, 1'b1, lat, fu, fs, rdy);
    n_cmp++;
    if ({fu, fs} !== 6'b000_000) begin n_bad++; $display("FAIL cascade_bad: got %b want 000000", {fu, fs}); end
    l_in = 1'b0; e_in = 1'b1; g_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_equal_hold();
    test_back_to_back();
    test_stats();
    test_abort();
`ifdef COMP_CASCADE_EN
    test_cascade();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
